m_axis_cq_req_parse: RTL
========================

M_AXIS_CQ_REQ_PARSE -- requirements
Module: m_axis_cq_req_parse

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, meaning stream width; only 256 is supported.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
- user_clk  in  1  sole clock; all logic on rising edge.
- user_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  256  legacy-format request TLP; DW0 at [31:0].
- s_axis_tkeep  in  32  byte enables; accepted but not used.
- s_axis_tlast  in  1  last input beat.
- s_axis_tuser  in  85  bar hit in [9:2].
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input accepted.
- req_valid/req_ready  out/in  1  descriptor handshake.
- req_we  out  1  1=write (fmt[1]), 0=read.
- req_addr  out  64  DW-aligned address, bits [1:0]=0.
- req_len  out  11  DW count; header 0 -> 1024.
- req_reqid/req_tag  out  16/8  requester ID, tag.
- req_first_be/req_last_be  out  4/4  byte enables.
- req_bar_hit  out  8  from s_axis_tuser[9:2] at SOP.
- req_tc/req_attr/req_ep  out  3/2/1  header fields.
- d_tdata  out  256  payload realigned, first payload DW at [31:0].
- d_tkeep  out  8  per-DW valid.
- d_tlast/d_tvalid/d_tready  out/out/in  1  payload handshake.

Function
REQ-003 SHALL decode DW0 as: len [9:0], attr [13:12], ep [14], tc [22:20], type [28:24], fmt [31:29]; and DW1 as: first_be [3:0], last_be [7:4], tag [15:8], reqid [31:16].
REQ-004 SHALL set header size H=4 when fmt[0]=1, with addr = {DW2, DW3[31:2], 2'b0}; otherwise H=3, with addr = {32'b0, DW2[31:2], 2'b0}.
REQ-005 SHALL use states IDLE, DATA, FLUSH, DROP.
REQ-006 SHALL assert s_axis_tready in IDLE only when the descriptor register is free (req_valid=0 or req_ready=1).
REQ-007 SHALL, on the accepted SOP beat, load the descriptor and assert req_valid the next cycle, held until req_ready.
REQ-008 SHALL, on the SOP beat, also load the 256-bit carry register and DW counter rem = req_len.
REQ-009 SHALL produce no d_ output on the SOP beat.
REQ-010 SHALL, for reads, return to IDLE on s_axis_tlast.
REQ-011 SHALL, for reads whose SOP beat lacks tlast, enter DROP.
REQ-012 SHALL, for writes, go to DATA when SOP has no tlast, else FLUSH.
REQ-013 SHALL in DATA drive s_axis_tready = d_tready and d_tvalid = s_axis_tvalid.
REQ-014 SHALL form d_tdata in DATA as {cur DW[H-1:0], carry DW[7:H]} and reload carry with cur on each transfer.
REQ-015 SHALL, on each d_ transfer, set d_tkeep = 8'hFF when rem>=8, else (1<<rem)-1, and decrement rem by min(rem,8).
REQ-016 SHALL assert d_tlast when rem<=8.
REQ-017 SHALL, in DATA on input tlast with rem>8 before the transfer, enter FLUSH and drive s_axis_tready=0.
REQ-018 SHALL in FLUSH output {zeros, carry DW[7:H]} with d_tlast=1, then go to IDLE.
REQ-019 SHALL, when d_tlast is sent without input tlast (over-length TLP), enter DROP.
REQ-020 SHALL in DROP hold s_axis_tready=1 and d_tvalid=0 until input tlast, then go to IDLE.
REQ-021 SHALL, on input tlast in DATA with rem>8 after this beat, still end the packet at the FLUSH beat with d_tlast=1.
REQ-022 SHALL have zero-cycle combinational latency from s_ to d_ in DATA, and one-cycle latency from SOP to req_valid.

Reset
REQ-023 SHALL, on user_reset, force state=IDLE, req_valid=0, d_tvalid=0, s_axis_tready=0 and rem=0.
REQ-024 SHALL NOT reset the carry register or descriptor fields.
REQ-025 SHALL, on reset mid-packet, discard the in-flight TLP; the next accepted beat is treated as SOP.

Configuration
REQ-026 SHALL, with CQ_PARSE_EP_DROP_EN defined, discard poisoned TLPs (ep=1): no descriptor and no payload, entering DROP or IDLE per tlast.
REQ-027 SHALL, without CQ_PARSE_EP_DROP_EN, forward poisoned TLPs normally with req_ep=1.

Verification
REQ-028 Bench SHALL apply a 3DW MemRd, len=1, addr 0x1000, tag 0x05 -> one descriptor with req_we=0, req_addr=0x1000, req_len=1, and no d_ beat.
REQ-029 Bench SHALL apply a 3DW MemWr, len=5, single beat -> FLUSH beat with d_tkeep=8'h1F, d_tlast=1, and payload DW0 equal to input DW3.
REQ-030 Bench SHALL apply a 4DW MemWr, len=12, addr 0x1_0000_0040, 2 input beats -> 2 d_ beats with d_tkeep FF then 0F, d_tlast on the second, and req_addr=0x100000040.
REQ-031 Bench SHALL hold req_ready=0 with two back-to-back MemRds -> s_axis_tready low on the second SOP until the first descriptor is taken.
REQ-032 Bench SHALL apply a write with len=2 spanning 3 input beats -> d_tlast on the first d_ beat and the remaining input beats dropped.
REQ-033 Bench SHALL apply an ep=1 MemWr with len=8 -> with the macro, no req_valid and no d_tvalid; without it, req_ep=1 and 8 DWs delivered.

Source files
------------

// File: rtl/m_axis_cq_req_parse.sv
// rtl/m_axis_cq_req_parse.sv - CQ request TLP parser: header to descriptor, payload realigned to DW0
// Build option: CQ_PARSE_EP_DROP_EN discards poisoned (EP=1) requests entirely.
`timescale 1ns/1ps
module m_axis_cq_req_parse #(
    parameter int DATA_WIDTH = 256
) (
    input  logic                     user_clk,
    input  logic                     user_reset,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic [84:0]              s_axis_tuser,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic                     req_we,
    output logic [63:0]              req_addr,
    output logic [10:0]              req_len,
    output logic [15:0]              req_reqid,
    output logic [7:0]               req_tag,
    output logic [3:0]               req_first_be,
    output logic [3:0]               req_last_be,
    output logic [7:0]               req_bar_hit,
    output logic [2:0]               req_tc,
    output logic [1:0]               req_attr,
    output logic                     req_ep,
    output logic [DATA_WIDTH-1:0]    d_tdata,
    output logic [DATA_WIDTH/32-1:0] d_tkeep,
    output logic                     d_tlast,
    output logic                     d_tvalid,
    input  logic                     d_tready
);

    typedef enum logic [1:0] {IDLE, DATA, FLUSH, DROP} state_t;
    state_t state, state_nxt;

    logic [31:0]  dw0, dw1, dw2, dw3;
    logic [10:0]  sop_len;
    logic         sop_drop;
    logic         desc_free, sop_fire, d_fire;
    logic [255:0] carry;
    logic         hdr4;
    logic [10:0]  rem, rem_dec;
    logic         rem_last;
    logic         unused_bits;

    assign dw0 = s_axis_tdata[31:0];
    assign dw1 = s_axis_tdata[63:32];
    assign dw2 = s_axis_tdata[95:64];
    assign dw3 = s_axis_tdata[127:96];

    assign sop_len = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
`ifdef CQ_PARSE_EP_DROP_EN
    assign sop_drop = dw0[14];
`else
    assign sop_drop = 1'b0;
`endif

    assign desc_free = !req_valid || req_ready;
    assign sop_fire  = (state == IDLE) && s_axis_tvalid && s_axis_tready;
    assign d_fire    = d_tvalid && d_tready;
    assign rem_dec   = (rem >= 11'd8) ? (rem - 11'd8) : 11'd0;
    assign rem_last  = (rem <= 11'd8);

    assign unused_bits = ^{s_axis_tkeep, s_axis_tuser[84:10], s_axis_tuser[1:0], dw0, dw3[1:0]};

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sop_fire) begin
                    if (sop_drop || !dw0[30]) begin
                        state_nxt = s_axis_tlast ? IDLE : DROP;
                    end else begin
                        state_nxt = s_axis_tlast ? FLUSH : DATA;
                    end
                end
            end
            DATA: begin
                if (s_axis_tvalid && d_tready) begin
                    if (rem_last) begin
                        // Payload complete; any further input beats belong to an over-length TLP
                        state_nxt = s_axis_tlast ? IDLE : DROP;
                    end else if (s_axis_tlast) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (d_tready) begin
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        d_tvalid      = 1'b0;
        d_tlast       = 1'b0;
        d_tkeep       = (rem >= 11'd8) ? 8'hFF : ((8'd1 << rem[2:0]) - 8'd1);
        d_tdata       = hdr4 ? {s_axis_tdata[127:0], carry[255:128]}
                             : {s_axis_tdata[95:0],  carry[255:96]};
        case (state)
            IDLE:  s_axis_tready = desc_free;
            DATA: begin
                s_axis_tready = d_tready;
                d_tvalid      = s_axis_tvalid;
                d_tlast       = rem_last;
            end
            FLUSH: begin
                d_tvalid = 1'b1;
                d_tlast  = 1'b1;
                d_tdata  = hdr4 ? {128'd0, carry[255:128]} : {96'd0, carry[255:96]};
            end
            DROP:  s_axis_tready = 1'b1;
            default: ;
        endcase
        if (user_reset) begin
            s_axis_tready = 1'b0;
            d_tvalid      = 1'b0;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            req_valid <= 1'b0;
            rem       <= 11'd0;
        end else begin
            if (sop_fire && !sop_drop) begin
                req_valid <= 1'b1;
            end else if (req_ready) begin
                req_valid <= 1'b0;
            end
            if (sop_fire) begin
                rem <= sop_len;
            end else if (d_fire) begin
                rem <= rem_dec;
            end
        end
    end

    // Carry and descriptor hold only data qualified by state/valid, so they need no reset
    always_ff @(posedge user_clk) begin
        if (sop_fire) begin
            carry <= s_axis_tdata;
            hdr4  <= dw0[29];
        end else if (state == DATA && d_fire) begin
            carry <= s_axis_tdata;
        end
        if (sop_fire && !sop_drop) begin
            req_we       <= dw0[30];
            req_addr     <= dw0[29] ? {dw2, dw3[31:2], 2'b00} : {32'd0, dw2[31:2], 2'b00};
            req_len      <= sop_len;
            req_reqid    <= dw1[31:16];
            req_tag      <= dw1[15:8];
            req_first_be <= dw1[3:0];
            req_last_be  <= dw1[7:4];
            req_bar_hit  <= s_axis_tuser[9:2];
            req_tc       <= dw0[22:20];
            req_attr     <= dw0[13:12];
            req_ep       <= dw0[14];
        end
    end

endmodule
